// File: rtl/pc_gen_pkg.sv
// Shared constants and helpers for the program-counter generator.
package pc_gen_pkg;

  // Front-end control states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Clears the two low bits of a target; cast down to XLEN at the use site.
  localparam logic [63:0] PC_ALIGN_MASK = ~64'd3;

  // Epoch increment; the caller truncates to EPOCH_W, which gives the wrap.
  function automatic logic [7:0] epoch_inc(input logic [7:0] e);
    return e + 8'd1;
  endfunction

endpackage

// File: rtl/pc_gen_redir_prio_sel.sv
// Fixed-priority selector: lowest asserted index wins, returns its target.
module redir_prio_sel #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]                      valid_i,
  input  logic [N*W-1:0]                    target_i,
  output logic                              any_valid_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
  output logic [W-1:0]                      target_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  assign any_valid_o = |valid_i;

  // Scan from highest to lowest so the lowest asserted index is the last writer
  always_comb begin
    idx_o    = '0;
    target_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        idx_o    = IDX_W'(k);
        target_o = target_i[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt control, prioritised redirects,
// halt-time redirect capture and epoch tagging of every issued PC.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 4,
  parameter int PC_INC    = 4,
  parameter int EPOCH_W   = 3
) (
  input  logic                                           clk_i,
  input  logic                                           reset_ni,
  input  logic                                           enable_i,
  input  logic [XLEN-1:0]                                boot_pc_i,
  input  logic [NUM_REDIR-1:0]                           redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0]                      redir_target_i,
  output logic [XLEN-1:0]                                pc_o,
  output logic                                           pc_valid_o,
  input  logic                                           pc_ready_i,
  output logic [EPOCH_W-1:0]                             epoch_o,
  output logic                                           redirect_o,
  output logic [((NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1)-1:0] redirect_src_o,
  output logic                                           misalign_o,
  output logic [1:0]                                     state_o
);

  // Handshake: pc_o is fetched when pc_valid_o && pc_ready_i at a rising edge.
  // pc_o only moves while valid on an accepted transfer or on a redirect,
  // and a redirect always bumps the epoch so stale fetches can be squashed.

  localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  logic [1:0]         r_state;
  logic [XLEN-1:0]    r_pc;
  logic               r_pc_valid;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_redirect;
  logic [IDX_W-1:0]   r_redirect_src;
  logic               r_misalign;
  logic               r_pend_valid;
  logic [XLEN-1:0]    r_pend_target;
  logic [IDX_W-1:0]   r_pend_idx;

  logic               w_live_any;
  logic [IDX_W-1:0]   w_live_idx;
  logic [XLEN-1:0]    w_live_target;
  logic               w_fin_any;
  logic [0:0]         w_fin_idx;
  logic [XLEN-1:0]    w_fin_target;
  logic [IDX_W-1:0]   w_apply_idx;
  logic               w_apply;
  logic               w_capture;

  // Pick the winning live request among the redirect channels
  redir_prio_sel #(.N(NUM_REDIR), .W(XLEN)) u_live_sel (
    .valid_i     (redir_valid_i),
    .target_i    (redir_target_i),
    .any_valid_o (w_live_any),
    .idx_o       (w_live_idx),
    .target_o    (w_live_target)
  );

  // Live request beats the held one; slot 0 is live, slot 1 is pending
  redir_prio_sel #(.N(2), .W(XLEN)) u_fin_sel (
    .valid_i     ({r_pend_valid, w_live_any}),
    .target_i    ({r_pend_target, w_live_target}),
    .any_valid_o (w_fin_any),
    .idx_o       (w_fin_idx),
    .target_o    (w_fin_target)
  );

  // Pending is only ever non-empty in HALT, so the final selector is valid
  // for every state; enable gates both application and capture.
  assign w_apply_idx = w_fin_idx[0] ? r_pend_idx : w_live_idx;
  assign w_apply     = enable_i && w_fin_any;
  assign w_capture   = !enable_i && w_live_any && (r_state != ST_IDLE) &&
                       (!r_pend_valid || (w_live_idx <= r_pend_idx));

  // State, PC, epoch, pending and pulse registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_pc_valid     <= 1'b0;
      r_epoch        <= '0;
      r_redirect     <= 1'b0;
      r_redirect_src <= '0;
      r_misalign     <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_pend_target  <= '0;
      r_pend_idx     <= '0;
    end else begin
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;

      if (w_apply) begin
        r_pc           <= w_fin_target & XLEN'(PC_ALIGN_MASK);
        r_epoch        <= EPOCH_W'(epoch_inc(8'(r_epoch)));
        r_redirect     <= 1'b1;
        r_redirect_src <= w_apply_idx;
        r_misalign     <= (w_fin_target[1:0] != 2'b00);
      end

      if (w_capture) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_live_target;
        r_pend_idx    <= w_live_idx;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            if (!w_apply) r_pc <= boot_pc_i;
            r_pc_valid <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            r_pc_valid <= 1'b0;
            r_state    <= ST_HALT;
          end else if (!w_apply && r_pc_valid && pc_ready_i) begin
            r_pc <= r_pc + XLEN'(PC_INC);
          end
        end
        ST_HALT: begin
          if (enable_i) begin
            r_pend_valid <= 1'b0;
            r_pc_valid   <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pc_o           = r_pc;
  assign pc_valid_o     = r_pc_valid;
  assign epoch_o        = r_epoch;
  assign redirect_o     = r_redirect;
  assign redirect_src_o = r_redirect_src;
  assign misalign_o     = r_misalign;
  assign state_o        = r_state;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: scenario tasks with a PC scoreboard queue.
module tb_pc_gen;

  localparam int XLEN = 32;
  localparam int NR   = 4;

  logic             clk_i;
  logic             reset_ni;
  logic             enable_i;
  logic [XLEN-1:0]  boot_pc_i;
  logic [NR-1:0]    redir_valid_i;
  logic [NR*XLEN-1:0] redir_target_i;
  logic [XLEN-1:0]  pc_o;
  logic             pc_valid_o;
  logic             pc_ready_i;
  logic [2:0]       epoch_o;
  logic             redirect_o;
  logic [1:0]       redirect_src_o;
  logic             misalign_o;
  logic [1:0]       state_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_pc;
  logic [2:0]      exp_epoch;

  pc_gen dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .enable_i       (enable_i),
    .boot_pc_i      (boot_pc_i),
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .pc_ready_i     (pc_ready_i),
    .epoch_o        (epoch_o),
    .redirect_o     (redirect_o),
    .redirect_src_o (redirect_src_o),
    .misalign_o     (misalign_o),
    .state_o        (state_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_redir(input int ch, input logic [XLEN-1:0] t);
    redir_valid_i[ch]            = 1'b1;
    redir_target_i[ch*XLEN +: XLEN] = t;
  endtask

  task automatic clr_redir();
    redir_valid_i  = '0;
    redir_target_i = '0;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    enable_i = 1'b0;
    pc_ready_i = 1'b0;
    boot_pc_i = '0;
    clr_redir();
    exp_q.delete();
    exp_epoch = 3'd0;
    tick();
    tick();
    reset_ni = 1'b1;
    #1;
  endtask

  // Scoreboard pop/compare of pc_o
  task automatic check_pc(input string name);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, pc_o=%h", name, pc_o);
    end else begin
      exp_pc = exp_q.pop_front();
      n_cmp++;
      if (pc_o !== exp_pc) begin
        n_bad++;
        $display("FAIL %s: pc_o=%h expected %h", name, pc_o, exp_pc);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || epoch_o !== 3'd0 || redirect_o !== 1'b0 ||
        redirect_src_o !== 2'd0 || misalign_o !== 1'b0 || state_o !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: pc=%h v=%b ep=%0d rd=%b src=%0d mis=%b st=%0d expected all zero",
               pc_o, pc_valid_o, epoch_o, redirect_o, redirect_src_o, misalign_o, state_o);
    end
    // Disabled IDLE ignores redirects and boot PC
    boot_pc_i = 32'h1234;
    set_redir(1, 32'h700);
    tick();
    clr_redir();
    n_cmp++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || epoch_o !== 3'd0 || state_o !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_hold: pc=%h v=%b ep=%0d st=%0d expected 0/0/0/0", pc_o, pc_valid_o, epoch_o, state_o);
    end
  endtask

  task automatic test_boot();
    do_reset();
    enable_i = 1'b1;
    boot_pc_i = 32'h1CC;
    pc_ready_i = 1'b1;
    exp_q.push_back(32'h1CC);
    exp_q.push_back(32'h1D0);
    exp_q.push_back(32'h1D4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pc("boot_seq");
      n_cmp++;
      if (epoch_o !== 3'd0 || pc_valid_o !== 1'b1 || state_o !== 2'd1) begin
        n_bad++;
        $display("FAIL boot_flags: ep=%0d v=%b st=%0d expected 0/1/1", epoch_o, pc_valid_o, state_o);
      end
    end
  endtask

  task automatic test_backpressure_redirect();
    do_reset();
    enable_i = 1'b1;
    boot_pc_i = 32'h200;
    pc_ready_i = 1'b0;
    exp_q.push_back(32'h200);
    tick();
    check_pc("bp_boot");
    set_redir(2, 32'h400);
    exp_q.push_back(32'h400);
    exp_epoch = exp_epoch + 3'd1;
    tick();
    clr_redir();
    check_pc("bp_redirect");
    n_cmp++;
    if (epoch_o !== exp_epoch || redirect_src_o !== 2'd2 || redirect_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_tags: ep=%0d src=%0d rd=%b expected %0d/2/1", epoch_o, redirect_src_o, redirect_o, exp_epoch);
    end
    exp_q.push_back(32'h400);
    tick();
    check_pc("bp_hold");
    n_cmp++;
    if (redirect_o !== 1'b0 || epoch_o !== exp_epoch) begin
      n_bad++;
      $display("FAIL bp_pulse_end: rd=%b ep=%0d expected 0/%0d", redirect_o, epoch_o, exp_epoch);
    end
  endtask

  task automatic test_priority();
    pc_ready_i = 1'b1;
    set_redir(0, 32'h80);
    set_redir(3, 32'h900);
    exp_q.push_back(32'h80);
    exp_epoch = exp_epoch + 3'd1;
    tick();
    clr_redir();
    check_pc("prio_win");
    n_cmp++;
    if (redirect_src_o !== 2'd0 || epoch_o !== exp_epoch) begin
      n_bad++;
      $display("FAIL prio_tags: src=%0d ep=%0d expected 0/%0d", redirect_src_o, epoch_o, exp_epoch);
    end
    exp_q.push_back(32'h84);
    tick();
    check_pc("prio_ch3_lost");
  endtask

  task automatic test_halt_capture();
    // pc_o is 0x84 here; halt wins over the accepted transfer
    enable_i = 1'b0;
    pc_ready_i = 1'b1;
    exp_q.push_back(32'h84);
    tick();
    check_pc("halt_enter");
    n_cmp++;
    if (pc_valid_o !== 1'b0 || state_o !== 2'd2) begin
      n_bad++;
      $display("FAIL halt_state: v=%b st=%0d expected 0/2", pc_valid_o, state_o);
    end
    set_redir(3, 32'h900);
    tick();
    clr_redir();
    set_redir(1, 32'h300);
    tick();
    clr_redir();
    set_redir(2, 32'h500);
    exp_q.push_back(32'h84);
    tick();
    clr_redir();
    check_pc("halt_pc_held");
    n_cmp++;
    if (epoch_o !== exp_epoch || pc_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_quiet: ep=%0d v=%b expected %0d/0", epoch_o, pc_valid_o, exp_epoch);
    end
    enable_i = 1'b1;
    pc_ready_i = 1'b0;
    exp_q.push_back(32'h300);
    exp_epoch = exp_epoch + 3'd1;
    tick();
    check_pc("halt_resume");
    n_cmp++;
    if (pc_valid_o !== 1'b1 || epoch_o !== exp_epoch || redirect_src_o !== 2'd1 ||
        redirect_o !== 1'b1 || state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL resume_tags: v=%b ep=%0d src=%0d rd=%b st=%0d expected 1/%0d/1/1/1",
               pc_valid_o, epoch_o, redirect_src_o, redirect_o, state_o, exp_epoch);
    end
    exp_q.push_back(32'h300);
    tick();
    check_pc("resume_single");
    n_cmp++;
    if (epoch_o !== exp_epoch || redirect_o !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_once: ep=%0d rd=%b expected %0d/0", epoch_o, redirect_o, exp_epoch);
    end
    // Live redirect on resume beats an empty/older pending; plain resume keeps pc
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    exp_q.push_back(32'h300);
    tick();
    check_pc("resume_plain");
    n_cmp++;
    if (epoch_o !== exp_epoch || pc_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_plain_tags: ep=%0d v=%b expected %0d/1", epoch_o, pc_valid_o, exp_epoch);
    end
  endtask

  task automatic test_misalign_wrap();
    pc_ready_i = 1'b1;
    set_redir(0, 32'h302);
    exp_q.push_back(32'h300);
    exp_epoch = exp_epoch + 3'd1;
    tick();
    clr_redir();
    check_pc("misalign_pc");
    n_cmp++;
    if (misalign_o !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_pulse: misalign_o=%b expected 1", misalign_o);
    end
    exp_q.push_back(32'h304);
    tick();
    check_pc("misalign_next");
    n_cmp++;
    if (misalign_o !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_clear: misalign_o=%b expected 0", misalign_o);
    end
    set_redir(3, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_epoch = exp_epoch + 3'd1;
    tick();
    clr_redir();
    check_pc("wrap_load");
    n_cmp++;
    if (misalign_o !== 1'b0 || redirect_src_o !== 2'd3) begin
      n_bad++;
      $display("FAIL wrap_tags: mis=%b src=%0d expected 0/3", misalign_o, redirect_src_o);
    end
    exp_q.push_back(32'h0);
    tick();
    check_pc("wrap_zero");
  endtask

  task automatic test_epoch_wrap();
    logic [XLEN-1:0] t;
    int ch;
    do_reset();
    enable_i = 1'b1;
    boot_pc_i = 32'h40;
    pc_ready_i = 1'b1;
    exp_q.push_back(32'h40);
    tick();
    check_pc("ep_boot");
    for (int i = 0; i < 8; i++) begin
      t  = $urandom_range(32'h0, 32'hFFFF) << 2;
      ch = $urandom_range(0, NR - 1);
      set_redir(ch, t);
      exp_q.push_back(t);
      exp_epoch = exp_epoch + 3'd1;
      tick();
      clr_redir();
      check_pc("ep_b2b");
      n_cmp++;
      if (epoch_o !== exp_epoch || redirect_src_o !== ch[1:0] || redirect_o !== 1'b1) begin
        n_bad++;
        $display("FAIL ep_b2b_tags: ep=%0d src=%0d rd=%b expected %0d/%0d/1",
                 epoch_o, redirect_src_o, redirect_o, exp_epoch, ch);
      end
    end
    n_cmp++;
    if (epoch_o !== 3'd0) begin
      n_bad++;
      $display("FAIL ep_wrap: epoch_o=%0d expected 0", epoch_o);
    end
  endtask

  task automatic test_async_reset();
    pc_ready_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    #2;
    reset_ni = 1'b0;
    #1;
    n_cmp++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || state_o !== 2'd0 || epoch_o !== 3'd0) begin
      n_bad++;
      $display("FAIL async_reset: pc=%h v=%b st=%0d ep=%0d expected 0/0/0/0",
               pc_o, pc_valid_o, state_o, epoch_o);
    end
    tick();
    reset_ni = 1'b1;
    exp_q.delete();
  endtask

  // Sequence and report
  initial begin
    reset_ni = 1'b0;
    enable_i = 1'b0;
    pc_ready_i = 1'b0;
    boot_pc_i = '0;
    redir_valid_i = '0;
    redir_target_i = '0;
    exp_epoch = 3'd0;
    test_reset();
    test_boot();
    test_backpressure_redirect();
    test_priority();
    test_halt_capture();
    test_misalign_wrap();
    test_epoch_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
